// File: rtl/magnitude_scheduler.sv
// Round-robin front end that shares one magnitude datapath between NUM_CHAN requesters.
// A tag FIFO pairs each in-order magnitude result with the channel that issued it.
module magnitude_scheduler #(
  parameter int NUM_CHAN      = 4,
  parameter int DATA_IN_BITS  = 16,
  parameter int TAG_DEPTH     = 32,
  parameter int CHAN_BITS     = $clog2(NUM_CHAN),
  parameter int DATA_OUT_BITS = DATA_IN_BITS + 1
)(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CHAN-1:0]              req_valid,
  output logic [NUM_CHAN-1:0]              req_ready,
  input  logic [NUM_CHAN*DATA_IN_BITS-1:0] req_data_1,
  input  logic [NUM_CHAN*DATA_IN_BITS-1:0] req_data_2,
  output logic                             mag_data_in_ready,
  output logic [DATA_IN_BITS-1:0]          mag_data_in_1,
  output logic [DATA_IN_BITS-1:0]          mag_data_in_2,
  input  logic                             mag_data_out_ready,
  input  logic [DATA_OUT_BITS-1:0]         mag_data_out,
  output logic                             res_valid,
  output logic [CHAN_BITS-1:0]             res_chan,
  output logic [DATA_OUT_BITS-1:0]         res_data,
  output logic [$clog2(TAG_DEPTH):0]       in_flight,
  output logic                             err_orphan
);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CHAN_BITS-1:0]     rr_q, rr_d;
  logic                     mag_vld_q;
  logic [DATA_IN_BITS-1:0]  mag_in1_q, mag_in2_q;
  logic [CHAN_BITS-1:0]     tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]         wr_q, rd_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     res_vld_q;
  logic [CHAN_BITS-1:0]     res_chan_q;
  logic [DATA_OUT_BITS-1:0] res_data_q;
  logic                     orphan_q;

  logic [NUM_CHAN-1:0]      grant;
  logic [CHAN_BITS-1:0]     gidx;
  logic [CHAN_BITS-1:0]     ci;
  logic                     found;
  int                       idx;
  logic                     full, push, pop;

  // Search starts at rr_q and wraps, so the first valid channel at or after rr_q wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    ci    = '0;
    for (int k = 0; k < NUM_CHAN; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CHAN) idx = idx - NUM_CHAN;
      ci = CHAN_BITS'(idx);
      if (!found && req_valid[ci]) begin
        found     = 1'b1;
        grant[ci] = 1'b1;
        gidx      = ci;
      end
    end
  end

  assign full      = (cnt_q == CNT_W'(TAG_DEPTH));
  assign req_ready = (full || rst) ? '0 : grant;
  assign push      = |req_ready;
  assign pop       = mag_data_out_ready && (cnt_q != '0);
  assign rr_d      = (gidx == CHAN_BITS'(NUM_CHAN - 1)) ? '0 : gidx + CHAN_BITS'(1);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Tag storage needs no reset: occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_q] <= gidx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= '0;
      mag_vld_q  <= 1'b0;
      mag_in1_q  <= '0;
      mag_in2_q  <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      res_vld_q  <= 1'b0;
      res_chan_q <= '0;
      res_data_q <= '0;
      orphan_q   <= 1'b0;
    end else begin
      mag_vld_q <= push;
      if (push) begin
        rr_q      <= rr_d;
        mag_in1_q <= req_data_1[gidx*DATA_IN_BITS +: DATA_IN_BITS];
        mag_in2_q <= req_data_2[gidx*DATA_IN_BITS +: DATA_IN_BITS];
        wr_q      <= wr_q + PTR_W'(1);
      end
      res_vld_q <= pop;
      if (pop) begin
        rd_q       <= rd_q + PTR_W'(1);
        res_chan_q <= tag_mem[rd_q];
        res_data_q <= mag_data_out;
      end
      cnt_q <= cnt_d;
      if (mag_data_out_ready && cnt_q == '0) orphan_q <= 1'b1;
    end
  end

  assign mag_data_in_ready = mag_vld_q;
  assign mag_data_in_1     = mag_in1_q;
  assign mag_data_in_2     = mag_in2_q;
  assign res_valid         = res_vld_q;
  assign res_chan          = res_chan_q;
  assign res_data          = res_data_q;
  assign in_flight         = cnt_q;
  assign err_orphan        = orphan_q;
endmodule

// File: tb/tb_magnitude_scheduler.sv
// Directed bench: a deep (16) and shallow (4) scheduler share stimulus; the magnitude side is driven by hand.
module tb_magnitude_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] rd1, rd2;
  logic        mor;
  logic [16:0] mdo;

  logic [3:0]  rr_a, rr_b;
  logic        miv_a, miv_b;
  logic [15:0] mi1_a, mi2_a, mi1_b, mi2_b;
  logic        rv_a, rv_b;
  logic [1:0]  rc_a, rc_b;
  logic [16:0] rdat_a, rdat_b;
  logic [4:0]  inf_a;
  logic [2:0]  inf_b;
  logic        eo_a, eo_b;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  magnitude_scheduler #(.NUM_CHAN(4), .DATA_IN_BITS(16), .TAG_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr_a),
    .req_data_1(rd1), .req_data_2(rd2),
    .mag_data_in_ready(miv_a), .mag_data_in_1(mi1_a), .mag_data_in_2(mi2_a),
    .mag_data_out_ready(mor), .mag_data_out(mdo),
    .res_valid(rv_a), .res_chan(rc_a), .res_data(rdat_a),
    .in_flight(inf_a), .err_orphan(eo_a)
  );

  magnitude_scheduler #(.NUM_CHAN(4), .DATA_IN_BITS(16), .TAG_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr_b),
    .req_data_1(rd1), .req_data_2(rd2),
    .mag_data_in_ready(miv_b), .mag_data_in_1(mi1_b), .mag_data_in_2(mi2_b),
    .mag_data_out_ready(mor), .mag_data_out(mdo),
    .res_valid(rv_b), .res_chan(rc_b), .res_data(rdat_b),
    .in_flight(inf_b), .err_orphan(eo_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; mor = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; rd1 = '0; rd2 = '0; mor = 1'b0; mdo = '0;
    repeat (2) tick();
    check("rst_mag_vld", 32'(miv_a), 0);
    check("rst_mag_in1", 32'(mi1_a), 0);
    check("rst_res_vld", 32'(rv_a), 0);
    check("rst_in_flight", 32'(inf_a), 0);
    check("rst_orphan", 32'(eo_a), 0);
    check("rst_req_ready", 32'(rr_a), 0);
    rst = 1'b0;

    // single channel: ch2 sends (3,4), magnitude returns 5
    rd1[2*16 +: 16] = 16'd3; rd2[2*16 +: 16] = 16'd4;
    req_valid = 4'b0100; #1;
    check("t1_grant", 32'(rr_a), 32'b0100);
    tick();
    req_valid = '0;
    check("t1_issue_vld", 32'(miv_a), 1);
    check("t1_issue_d1", 32'(mi1_a), 3);
    check("t1_issue_d2", 32'(mi2_a), 4);
    check("t1_in_flight", 32'(inf_a), 1);
    mor = 1'b1; mdo = 17'd5;
    tick();
    mor = 1'b0;
    check("t1_res_vld", 32'(rv_a), 1);
    check("t1_res_chan", 32'(rc_a), 2);
    check("t1_res_data", 32'(rdat_a), 5);
    check("t1_in_flight0", 32'(inf_a), 0);
    check("t1_mag_vld_low", 32'(miv_a), 0);
    check("t1_mag_in_hold", 32'(mi1_a), 3);
    tick();
    check("t1_res_vld_low", 32'(rv_a), 0);
    check("t1_res_chan_hold", 32'(rc_a), 2);
    check("t1_orphan", 32'(eo_a), 0);

    // all four valid for 8 cycles: strict rotation 0,1,2,3,...
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rd1[i*16 +: 16] = 16'(10 + i);
      rd2[i*16 +: 16] = 16'(20 + i);
    end
    req_valid = 4'hF; #1;
    for (int k = 0; k < 8; k++) begin
      check("t2_grant", 32'(rr_a), 32'(1 << (k % 4)));
      tick();
      check("t2_issue_d1", 32'(mi1_a), 32'(10 + k % 4));
      check("t2_issue_d2", 32'(mi2_a), 32'(20 + k % 4));
    end
    req_valid = '0;
    check("t2_in_flight8", 32'(inf_a), 8);
    mor = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mdo = 17'(100 + k);
      tick();
      check("t2_res_vld", 32'(rv_a), 1);
      check("t2_res_chan", 32'(rc_a), 32'(k % 4));
      check("t2_res_data", 32'(rdat_a), 32'(100 + k));
    end
    mor = 1'b0;
    check("t2_in_flight0", 32'(inf_a), 0);
    tick();
    check("t2_res_idle", 32'(rv_a), 0);
    check("t2_orphan", 32'(eo_a), 0);

    // shallow instance fills at 4 and blocks until a pop; pop cycle still blocks push
    do_reset();
    req_valid = 4'hF; #1;
    for (int k = 0; k < 4; k++) begin
      check("t3_grant", 32'(rr_b), 32'(1 << k));
      tick();
    end
    check("t3_full_cnt", 32'(inf_b), 4);
    check("t3_full_ready", 32'(rr_b), 0);
    tick();
    check("t3_full_hold", 32'(inf_b), 4);
    check("t3_full_ready2", 32'(rr_b), 0);
    mor = 1'b1; mdo = 17'd7; #1;
    check("t3_pop_blocked", 32'(rr_b), 0);
    tick();
    mor = 1'b0;
    check("t3_after_pop", 32'(inf_b), 3);
    check("t3_pop_res_chan", 32'(rc_b), 0);
    #1;
    check("t3_ready_again", 32'(rr_b), 32'b0001);
    tick();
    req_valid = '0;
    check("t3_refill", 32'(inf_b), 4);

    // ch1 alone, then ch3 joins: grants alternate without skipping
    do_reset();
    req_valid = 4'b0010; #1;
    check("t4_g0", 32'(rr_a), 32'b0010);
    tick();
    check("t4_g1", 32'(rr_a), 32'b0010);
    tick();
    req_valid = 4'b1010; #1;
    check("t4_g2", 32'(rr_a), 32'b1000);
    tick();
    check("t4_g3", 32'(rr_a), 32'b0010);
    tick();
    check("t4_g4", 32'(rr_a), 32'b1000);
    tick();
    check("t4_g5", 32'(rr_a), 32'b0010);
    tick();
    req_valid = '0;
    check("t4_in_flight", 32'(inf_a), 6);

    // orphan result with empty FIFO
    do_reset();
    mor = 1'b1; mdo = 17'h1ABC;
    tick();
    mor = 1'b0;
    check("t5_orphan", 32'(eo_a), 1);
    check("t5_no_res", 32'(rv_a), 0);
    check("t5_in_flight", 32'(inf_a), 0);
    tick();
    check("t5_sticky", 32'(eo_a), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_cleared", 32'(eo_a), 0);

    // reset with 10 in flight, then restart from ch0
    do_reset();
    req_valid = 4'hF;
    repeat (10) tick();
    check("t6_in_flight10", 32'(inf_a), 10);
    check("t6_issuing", 32'(miv_a), 1);
    rst = 1'b1; #1;
    check("t6_ready_in_rst", 32'(rr_a), 0);
    tick();
    check("t6_mag_vld", 32'(miv_a), 0);
    check("t6_in_flight0", 32'(inf_a), 0);
    check("t6_mag_in1", 32'(mi1_a), 0);
    check("t6_res_vld", 32'(rv_a), 0);
    check("t6_orphan", 32'(eo_a), 0);
    rst = 1'b0; #1;
    check("t6_restart_grant", 32'(rr_a), 32'b0001);
    tick();
    req_valid = '0;
    check("t6_restart_d1", 32'(mi1_a), 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
